// File: rtl/chs_conf_encoder.sv
// -----------------------------------------------------------------------------
// chs_conf_encoder
//
// Produces the 8-bit chs_conf word for the climate-system mode/power decoder.
// A mode/power request taken over a valid/ready handshake is reached by
// walking the word one step at a time:
//   - power moves toward the target,
//   - a mode change always ramps down to power 0, flips the mode bit while
//     power is 0, then ramps up to the new target.
// Every change of the word is flagged by a one-cycle conf_strobe.
//
// chs_conf layout: [7] mode (1 = heat), [6] enable (power != 0),
//                  [5:4] change counter, [3:0] power.
//
// Build option (macro CHS_SOFTSTART_EN):
//   defined   : power moves one level every RAMP_DIV cycles.
//   undefined : each ramp phase completes in a single cycle, jumping straight
//               to its floor/target; the divider counter does not exist.
//
// Parameters:
//   RAMP_DIV   clock cycles between consecutive power steps (1..255)
//   MAX_POWER  highest power level emitted; larger requests are clamped
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset
//   req_valid    request present
//   req_ready    encoder can accept a request (high only in IDLE)
//   req_mode     requested mode, 1 = heat, 0 = cool
//   req_power    requested power level 0..15
//   chs_conf     encoded configuration word (registered)
//   conf_strobe  one-cycle pulse in each cycle chs_conf changed (registered)
//   busy         high whenever the sequencer is not in IDLE
// -----------------------------------------------------------------------------
module chs_conf_encoder #(
   parameter int RAMP_DIV  = 4,
   parameter int MAX_POWER = 15
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic       req_mode,
   input  logic [3:0] req_power,
   output logic [7:0] chs_conf,
   output logic       conf_strobe,
   output logic       busy
);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      RAMP_DOWN = 2'd1,
      SWITCH    = 2'd2,
      RAMP_UP   = 2'd3
   } state_t;

   localparam logic [3:0] MAX_POWER_C = 4'(MAX_POWER);

`ifdef CHS_SOFTSTART_EN
   // Last count value of the step divider; a step happens on its wrap.
   localparam logic [7:0] DIV_LAST_C = 8'(RAMP_DIV - 1);
`endif

   // Assemble the configuration word; the counter field carries the number
   // of earlier updates (mod 4), so the very first update shows 2'b00.
   function automatic logic [7:0] encode_word(input logic       mode,
                                              input logic [3:0] power,
                                              input logic [1:0] cnt);
      return {mode, (power != 4'd0), cnt, power};
   endfunction

   state_t     state_q,      state_d;
   logic       cur_mode_q,   cur_mode_d;
   logic [3:0] cur_power_q,  cur_power_d;
   logic       tgt_mode_q,   tgt_mode_d;
   logic [3:0] tgt_power_q,  tgt_power_d;
   logic [1:0] seq_q,        seq_d;
   logic [7:0] chs_conf_q,   chs_conf_d;
   logic       strobe_q,     strobe_d;
`ifdef CHS_SOFTSTART_EN
   logic [7:0] div_cnt_q,    div_cnt_d;
`endif

   logic [3:0] req_clamp_s;
   logic [3:0] floor_s;
   logic [3:0] down_power_s;
   logic [3:0] up_power_s;
   logic       step_s;
   logic       mode_diff_s;

   // Per-step helpers: clamp, ramp-down floor, next power levels, step enable.
   always_comb begin
      req_clamp_s = (req_power > MAX_POWER_C) ? MAX_POWER_C : req_power;
      mode_diff_s = (tgt_mode_q != cur_mode_q);
      // A pending mode change must reach 0 before the mode bit may flip.
      floor_s     = mode_diff_s ? 4'd0 : tgt_power_q;
`ifdef CHS_SOFTSTART_EN
      step_s       = (div_cnt_q == DIV_LAST_C);
      down_power_s = cur_power_q - 4'd1;
      up_power_s   = cur_power_q + 4'd1;
`else
      step_s       = 1'b1;
      down_power_s = floor_s;
      up_power_s   = tgt_power_q;
`endif
   end

   // Next-state and word-update logic of the sequencer.
   always_comb begin
      state_d     = state_q;
      cur_mode_d  = cur_mode_q;
      cur_power_d = cur_power_q;
      tgt_mode_d  = tgt_mode_q;
      tgt_power_d = tgt_power_q;
      seq_d       = seq_q;
      chs_conf_d  = chs_conf_q;
      strobe_d    = 1'b0;
`ifdef CHS_SOFTSTART_EN
      div_cnt_d   = div_cnt_q;
`endif

      case (state_q)
         IDLE: begin
            // req_ready is high throughout IDLE, so valid alone is a handshake.
            if (req_valid) begin
               tgt_mode_d  = req_mode;
               tgt_power_d = req_clamp_s;
`ifdef CHS_SOFTSTART_EN
               div_cnt_d   = 8'd0;
`endif
               if (req_mode != cur_mode_q) begin
                  if (cur_power_q != 4'd0) begin
                     state_d = RAMP_DOWN;
                  end else begin
                     state_d = SWITCH;
                  end
               end else if (req_clamp_s > cur_power_q) begin
                  state_d = RAMP_UP;
               end else if (req_clamp_s < cur_power_q) begin
                  state_d = RAMP_DOWN;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               state_d = IDLE;
            end
         end

         RAMP_DOWN: begin
            if (step_s) begin
               cur_power_d = down_power_s;
               chs_conf_d  = encode_word(cur_mode_q, down_power_s, seq_q);
               seq_d       = seq_q + 2'd1;
               strobe_d    = 1'b1;
`ifdef CHS_SOFTSTART_EN
               div_cnt_d   = 8'd0;
`endif
               if (down_power_s == floor_s) begin
                  state_d = mode_diff_s ? SWITCH : IDLE;
               end else begin
                  state_d = RAMP_DOWN;
               end
            end else begin
`ifdef CHS_SOFTSTART_EN
               div_cnt_d = div_cnt_q + 8'd1;
`endif
               state_d   = RAMP_DOWN;
            end
         end

         SWITCH: begin
            // Power is 0 here, so the decoder sees the flip with output off.
            cur_mode_d = tgt_mode_q;
            chs_conf_d = encode_word(tgt_mode_q, cur_power_q, seq_q);
            seq_d      = seq_q + 2'd1;
            strobe_d   = 1'b1;
`ifdef CHS_SOFTSTART_EN
            div_cnt_d  = 8'd0;
`endif
            if (tgt_power_q != 4'd0) begin
               state_d = RAMP_UP;
            end else begin
               state_d = IDLE;
            end
         end

         RAMP_UP: begin
            if (step_s) begin
               cur_power_d = up_power_s;
               chs_conf_d  = encode_word(cur_mode_q, up_power_s, seq_q);
               seq_d       = seq_q + 2'd1;
               strobe_d    = 1'b1;
`ifdef CHS_SOFTSTART_EN
               div_cnt_d   = 8'd0;
`endif
               if (up_power_s == tgt_power_q) begin
                  state_d = IDLE;
               end else begin
                  state_d = RAMP_UP;
               end
            end else begin
`ifdef CHS_SOFTSTART_EN
               div_cnt_d = div_cnt_q + 8'd1;
`endif
               state_d   = RAMP_UP;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State, datapath and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         cur_mode_q  <= 1'b0;
         cur_power_q <= 4'd0;
         tgt_mode_q  <= 1'b0;
         tgt_power_q <= 4'd0;
         seq_q       <= 2'd0;
         chs_conf_q  <= 8'h00;
         strobe_q    <= 1'b0;
`ifdef CHS_SOFTSTART_EN
         div_cnt_q   <= 8'd0;
`endif
      end else begin
         state_q     <= state_d;
         cur_mode_q  <= cur_mode_d;
         cur_power_q <= cur_power_d;
         tgt_mode_q  <= tgt_mode_d;
         tgt_power_q <= tgt_power_d;
         seq_q       <= seq_d;
         chs_conf_q  <= chs_conf_d;
         strobe_q    <= strobe_d;
`ifdef CHS_SOFTSTART_EN
         div_cnt_q   <= div_cnt_d;
`endif
      end
   end

   // Handshake and status come straight from the state register.
   assign req_ready   = (state_q == IDLE);
   assign busy        = (state_q != IDLE);
   assign chs_conf    = chs_conf_q;
   assign conf_strobe = strobe_q;

endmodule
